// File: rtl/obi_conf_sequencer.sv
// obi_conf_sequencer: OBI master that replays a register-write table, then polls a done register
// Ports: clk_i/rst_ni (async active-low); tbl_we_i/tbl_idx_i/tbl_addr_i/tbl_data_i load the write
// table while idle; num_i/start_i launch a sequence; busy_o/done_o/err_o report status;
// obi_* is the OBI master side (one outstanding transaction).
// Build option: define TIMEOUT_EN for a TMO_W-bit watchdog that aborts into sticky err_o.
module obi_conf_sequencer #(
    parameter int                DEPTH      = 8,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] POLL_ADDR  = 32'h20,
    parameter logic [DATA_W-1:0] POLL_MASK  = 32'h1,
    parameter logic [DATA_W-1:0] POLL_VALUE = 32'h1,
    parameter int                POLL_GAP   = 16,
    parameter int                TMO_W      = 24,
    localparam int               AW         = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int               NW         = AW + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tbl_we_i,
    input  logic [AW-1:0]       tbl_idx_i,
    input  logic [ADDR_W-1:0]   tbl_addr_i,
    input  logic [DATA_W-1:0]   tbl_data_i,
    input  logic [NW-1:0]       num_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                obi_req_o,
    output logic                obi_we_o,
    output logic [DATA_W/8-1:0] obi_be_o,
    output logic [ADDR_W-1:0]   obi_addr_o,
    output logic [DATA_W-1:0]   obi_wdata_o,
    input  logic                obi_gnt_i,
    input  logic                obi_rvalid_i,
    input  logic [DATA_W-1:0]   obi_rdata_i
);
    localparam int GW = POLL_GAP > 0 ? $clog2(POLL_GAP + 1) : 1;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, POLL_WAIT, DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tbl_addr_q [DEPTH];
    logic [DATA_W-1:0] tbl_data_q [DEPTH];
    logic [NW-1:0]     num_q, num_d, idx_q, idx_d, idx_inc, num_clamp;
    logic [GW-1:0]     gap_q, gap_d;
    logic              match;
    assign num_clamp = num_i > NW'(DEPTH) ? NW'(DEPTH) : num_i;
    assign idx_inc   = idx_q + NW'(1);
    assign match     = (obi_rdata_i & POLL_MASK) == POLL_VALUE;
`ifdef TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                num_d   = start_i ? num_clamp : num_q;
                idx_d   = start_i ? '0 : idx_q;
                state_d = !start_i ? IDLE : num_clamp != '0 ? WR_REQ : RD_REQ;
            end
            WR_REQ: state_d = obi_gnt_i ? WR_RSP : WR_REQ;
            WR_RSP: begin
                idx_d   = obi_rvalid_i ? idx_inc : idx_q;
                state_d = !obi_rvalid_i ? WR_RSP : idx_inc == num_q ? RD_REQ : WR_REQ;
            end
            RD_REQ: state_d = obi_gnt_i ? RD_RSP : RD_REQ;
            RD_RSP: begin
                gap_d   = GW'(POLL_GAP);
                state_d = !obi_rvalid_i ? RD_RSP : match ? DONE : POLL_GAP == 0 ? RD_REQ : POLL_WAIT;
            end
            POLL_WAIT: begin
                gap_d   = gap_q - GW'(1);
                state_d = gap_q == '0 ? RD_REQ : POLL_WAIT;
            end
            default: state_d = IDLE;
        endcase
`ifdef TIMEOUT_EN
        // A matching response in the expiry cycle still completes normally.
        tmo_d = state_q == IDLE ? '0 : tmo_q + TMO_W'(1);
        err_d = state_q == IDLE && start_i ? 1'b0 : err_q;
        if (&tmo_q && state_q != IDLE && state_q != DONE && !(state_q == RD_RSP && obi_rvalid_i && match)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
`endif
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
`ifdef TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
`ifdef TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_addr_q[i] <= '0;
                tbl_data_q[i] <= '0;
            end
        end else if (tbl_we_i && state_q == IDLE) begin
            tbl_addr_q[tbl_idx_i] <= tbl_addr_i;
            tbl_data_q[tbl_idx_i] <= tbl_data_i;
        end
    end
`ifdef TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign obi_req_o   = state_q == WR_REQ || state_q == RD_REQ;
    assign obi_we_o    = state_q == WR_REQ;
    assign obi_be_o    = '1;
    assign obi_addr_o  = state_q == RD_REQ ? POLL_ADDR : state_q == WR_REQ ? tbl_addr_q[idx_q[AW-1:0]] : '0;
    assign obi_wdata_o = state_q == WR_REQ ? tbl_data_q[idx_q[AW-1:0]] : '0;
endmodule

// File: tb/tb_obi_conf_sequencer.sv
// tb_obi_conf_sequencer: table-driven bench with an OBI slave model and a transaction scoreboard
module tb_obi_conf_sequencer;
`ifdef TIMEOUT_EN
    localparam int TW = 8;
`else
    localparam int TW = 24;
`endif
    localparam int GAP = 16;
    logic        clk = 1'b0, rst_ni = 1'b0;
    logic        tbl_we_i = 1'b0, start_i = 1'b0;
    logic [2:0]  tbl_idx_i = '0;
    logic [31:0] tbl_addr_i = '0, tbl_data_i = '0;
    logic [3:0]  num_i = '0;
    logic        busy_o, done_o, err_o, obi_req_o, obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_addr_o, obi_wdata_o;
    logic        obi_gnt_i = 1'b0, obi_rvalid_i = 1'b0;
    logic [31:0] obi_rdata_i = '0;

    obi_conf_sequencer #(.DEPTH(8), .POLL_GAP(GAP), .TMO_W(TW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .tbl_we_i(tbl_we_i), .tbl_idx_i(tbl_idx_i),
        .tbl_addr_i(tbl_addr_i), .tbl_data_i(tbl_data_i), .num_i(num_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .obi_req_o(obi_req_o), .obi_we_o(obi_we_o),
        .obi_be_o(obi_be_o), .obi_addr_o(obi_addr_o), .obi_wdata_o(obi_wdata_o),
        .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i));

    always #5 clk = ~clk;

    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
    typedef struct {int num; int gmax; int rmax; int zeros; bit poke; int exp_wr; int exp_rd;} vec_t;
    txn_t sb_q[$];
    int n_vec = 0, n_err = 0;
    int gmax = 0, rmax = 0, rsp_fix = 0, stall_left = 0, rsp_wait = 0, zeros_left = 0;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, cyc = 0, last_rv_cyc = 0;
    bit rsp_pend = 0, pend_rd = 0, pend_match = 0, stalled = 0, req_prev = 0, last_rd = 0, sb_en = 1, spur = 0;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // OBI slave: decides gnt/rvalid for the next rising edge and checks the master protocol.
    always @(negedge clk) begin
        cyc++;
        obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b0;
        if (!rst_ni) begin
            rsp_pend = 0;
            stalled = 0;
            stall_left = 0;
        end else begin
            if (done_o) begin
                done_cnt++;
                chk("done_latency", cyc, last_rv_cyc + 1);
            end
            if (rsp_pend) chk("req_while_outstanding", obi_req_o, 0);
            if (spur && !rsp_pend) begin
                obi_rvalid_i = 1'b1;
                obi_rdata_i = '1;
                spur = 0;
            end else if (rsp_pend) begin
                if (rsp_wait == 0) begin
                    obi_rvalid_i = 1'b1;
                    obi_rdata_i = pend_rd && pend_match ? ($urandom | 32'h1) : ($urandom & ~32'h1);
                    rsp_pend = 0;
                    last_rv_cyc = cyc;
                end else rsp_wait--;
            end else if (obi_req_o) begin
                if (stalled) begin
                    chk("stall_we", obi_we_o, s_we);
                    chk("stall_addr", obi_addr_o, s_addr);
                    chk("stall_wdata", obi_wdata_o, s_wdata);
                end
                if (!req_prev && !obi_we_o && last_rd) begin
                    n_vec++;
                    if (cyc - last_rv_cyc - 1 < GAP) begin
                        n_err++;
                        $display("FAIL poll_gap: got %0d idle cycles, need >= %0d", cyc - last_rv_cyc - 1, GAP);
                    end
                end
                if (stall_left == 0) begin
                    obi_gnt_i = 1'b1;
                    stalled = 0;
                    stall_left = $urandom_range(0, gmax);
                    rsp_pend = 1;
                    rsp_wait = rsp_fix > 0 ? rsp_fix : $urandom_range(0, rmax);
                    pend_rd = !obi_we_o;
                    last_rd = !obi_we_o;
                    pend_match = zeros_left == 0;
                    if (obi_we_o) wr_cnt++;
                    else begin
                        rd_cnt++;
                        if (zeros_left > 0) zeros_left--;
                    end
                    if (sb_en) begin
                        if (sb_q.size() == 0) chk("unexpected_txn_addr", obi_addr_o, 32'hFFFF_FFFF);
                        else begin
                            txn_t e;
                            e = sb_q.pop_front();
                            chk("txn_we", obi_we_o, e.we);
                            chk("txn_addr", obi_addr_o, e.addr);
                            if (e.we) chk("txn_wdata", obi_wdata_o, e.data);
                            chk("txn_be", obi_be_o, 4'hF);
                        end
                    end
                end else begin
                    stall_left--;
                    stalled = 1;
                    s_we = obi_we_o;
                    s_addr = obi_addr_o;
                    s_wdata = obi_wdata_o;
                end
            end
            req_prev = obi_req_o;
        end
    end

    task automatic wait_done();
        for (int c = 0; c < 3000 && done_cnt == 0; c++) tick();
        tick();
        tick();
    endtask

    task automatic run_vec(input vec_t t, input int v);
        logic [31:0] ta [8];
        logic [31:0] td [8];
        logic [31:0] sd [5];
        txn_t e;
        sd = '{32'h8000, 32'h0, 32'h0, 32'h0, 32'h1};
        gmax = t.gmax; rmax = t.rmax; zeros_left = t.zeros;
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; last_rd = 0; sb_en = 1;
        for (int i = 0; i < 8; i++) begin
            ta[i] = 32'hC + 4 * i + 32'h100 * v;
            td[i] = (v == 0 && i < 5) ? sd[i] : $urandom;
        end
        for (int i = 1; i < 8; i++) begin
            tbl_we_i = 1; tbl_idx_i = 3'(i); tbl_addr_i = ta[i]; tbl_data_i = td[i];
            tick();
        end
        // Entry 0 is written in the same cycle as the launch and must be used.
        tbl_idx_i = 0; tbl_addr_i = ta[0]; tbl_data_i = td[0]; start_i = 1; num_i = 4'(t.num);
        for (int i = 0; i < t.exp_wr; i++) begin
            e.we = 1; e.addr = ta[i]; e.data = td[i];
            sb_q.push_back(e);
        end
        for (int i = 0; i < t.exp_rd; i++) begin
            e.we = 0; e.addr = 32'h20; e.data = 0;
            sb_q.push_back(e);
        end
        tick();
        tbl_we_i = 0; start_i = 0;
        chk("busy_after_start", busy_o, 1);
        if (t.poke) begin
            start_i = 1; num_i = 1; tbl_we_i = 1; tbl_idx_i = 4;
            tbl_addr_i = 32'hDEAD_0000; tbl_data_i = 32'hBAD;
            tick();
            start_i = 0; tbl_we_i = 0;
        end
        wait_done();
        chk("done_pulses", done_cnt, 1);
        chk("busy_after_done", busy_o, 0);
        chk("write_count", wr_cnt, t.exp_wr);
        chk("read_count", rd_cnt, t.exp_rd);
        chk("sb_left", sb_q.size(), 0);
        chk("err_clear", err_o, 0);
        sb_q.delete();
    endtask

    vec_t vecs [6];
    initial begin
        vecs[0] = '{num: 5,  gmax: 0, rmax: 0, zeros: 3, poke: 0, exp_wr: 5, exp_rd: 4};
        vecs[1] = '{num: 5,  gmax: 7, rmax: 3, zeros: 1, poke: 1, exp_wr: 5, exp_rd: 2};
        vecs[2] = '{num: 0,  gmax: 0, rmax: 0, zeros: 0, poke: 1, exp_wr: 0, exp_rd: 1};
        vecs[3] = '{num: 8,  gmax: 3, rmax: 2, zeros: 2, poke: 0, exp_wr: 8, exp_rd: 3};
        vecs[4] = '{num: 12, gmax: 2, rmax: 1, zeros: 0, poke: 0, exp_wr: 8, exp_rd: 1};
        vecs[5] = '{num: 1,  gmax: 7, rmax: 7, zeros: 1, poke: 1, exp_wr: 1, exp_rd: 2};
        #12;
        chk("rst_req", obi_req_o, 0);
        chk("rst_we", obi_we_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_addr", obi_addr_o, 0);
        tick();
        rst_ni = 1;
        tick();
        done_cnt = 0; spur = 1;
        repeat (3) tick();
        chk("spurious_rvalid_done", done_cnt, 0);
        chk("spurious_rvalid_busy", busy_o, 0);
        for (int v = 0; v < 6; v++) run_vec(vecs[v], v);
        // Reset while a write response is outstanding.
        sb_en = 0; gmax = 0; rsp_fix = 10; zeros_left = 0;
        start_i = 1; num_i = 5;
        tick();
        start_i = 0;
        for (int c = 0; c < 50 && !rsp_pend; c++) tick();
        tick();
        #2 rst_ni = 0;
        #1;
        chk("midrst_req", obi_req_o, 0);
        chk("midrst_busy", busy_o, 0);
        tick();
        tick();
        rst_ni = 1; rsp_fix = 0;
        begin
            txn_t e;
            for (int i = 0; i < 5; i++) begin
                e.we = 1; e.addr = 0; e.data = 0;
                sb_q.push_back(e);
            end
            e.we = 0; e.addr = 32'h20; e.data = 0;
            sb_q.push_back(e);
        end
        sb_en = 1; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; last_rd = 0;
        start_i = 1; num_i = 5;
        tick();
        start_i = 0;
        wait_done();
        chk("postrst_done", done_cnt, 1);
        chk("postrst_writes", wr_cnt, 5);
        chk("postrst_sb_left", sb_q.size(), 0);
`ifdef TIMEOUT_EN
        sb_en = 0; zeros_left = 100000; gmax = 0; rmax = 0; done_cnt = 0;
        start_i = 1; num_i = 0;
        tick();
        start_i = 0;
        for (int c = 0; c < 400 && !err_o; c++) tick();
        chk("tmo_err", err_o, 1);
        repeat (20) begin
            tick();
            chk("tmo_req_low", obi_req_o, 0);
        end
        chk("tmo_no_done", done_cnt, 0);
        chk("tmo_err_sticky", err_o, 1);
        start_i = 1;
        tick();
        start_i = 0;
        chk("tmo_err_cleared", err_o, 0);
        rst_ni = 0;
        tick();
        rst_ni = 1;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
